// File: rtl/core_pkg.sv
// Core-wide widths and shared types for the front end.
package core_pkg;

    localparam int XLEN        = 32;
    localparam int FETCH_WIDTH = 2;
    localparam int FQ_DEPTH    = 8;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fq_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Circular instruction queue decoupling fetch from decode, FETCH_W wide on
// both sides, with conservative back-pressure and single-cycle flush.
module fetch_queue #(
    parameter int XLEN    = core_pkg::XLEN,
    parameter int FETCH_W = core_pkg::FETCH_WIDTH,
    parameter int DEPTH   = core_pkg::FQ_DEPTH
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          flush,
    input  logic [FETCH_W-1:0]            if_valid,
    input  logic [FETCH_W-1:0][XLEN-1:0]  if_pc,
    input  logic [FETCH_W-1:0][XLEN-1:0]  if_instr,
    output logic                          stall,
    output logic [FETCH_W-1:0]            id_valid,
    output logic [FETCH_W-1:0][XLEN-1:0]  id_pc,
    output logic [FETCH_W-1:0][XLEN-1:0]  id_instr,
    input  logic                          id_ready,
    output logic [$clog2(DEPTH):0]        fq_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    // Local copy of the entry layout so a non-default XLEN still works.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } entry_t;

    function automatic logic [CW-1:0] popcount(input logic [FETCH_W-1:0] v);
        logic [CW-1:0] n;
        n = '0;
        for (int i = 0; i < FETCH_W; i++) begin
            n = n + CW'(v[i]);
        end
        return n;
    endfunction

    entry_t          entry_q [DEPTH];
    entry_t          entry_d [DEPTH];
    logic [PW-1:0]   head_q, head_d;
    logic [PW-1:0]   tail_q, tail_d;
    logic [CW-1:0]   count_q, count_d;
    logic [CW-1:0]   enq_n, deq_n;
    logic [PW-1:0]   wr_off;
    logic            enq_en;

    // Stall looks only at registered occupancy, ignoring same-cycle dequeue.
    assign stall    = (count_q > CW'(DEPTH - FETCH_W));
    assign enq_en   = !stall && !flush;
    assign fq_count = count_q;

    generate
        for (genvar gi = 0; gi < FETCH_W; gi++) begin : g_out
            assign id_valid[gi] = (count_q > CW'(gi)) && !flush;
            assign id_pc[gi]    = entry_q[head_q + PW'(gi)].pc;
            assign id_instr[gi] = entry_q[head_q + PW'(gi)].instr;
        end
    endgenerate

    always_comb begin
        entry_d = entry_q;
        wr_off  = '0;
        enq_n   = enq_en ? popcount(if_valid) : '0;
        deq_n   = id_ready ? popcount(id_valid) : '0;

        // Valid slots are packed densely starting at tail, in slot order.
        for (int s = 0; s < FETCH_W; s++) begin
            if (enq_en && if_valid[s]) begin
                entry_d[tail_q + wr_off] = '{pc: if_pc[s], instr: if_instr[s]};
                wr_off = wr_off + PW'(1);
            end
        end

        head_d  = head_q + PW'(deq_n);
        tail_d  = tail_q + PW'(enq_n);
        count_d = count_q + enq_n - deq_n;

        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Payload storage carries no reset; validity is tracked by count alone.
    always_ff @(posedge clk) begin
        entry_q <= entry_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_count_bound: assert (count_q <= CW'(DEPTH));
            a_no_underflow: assert (deq_n <= count_q);
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Randomized and directed bench for fetch_queue against a queue-based model.
module tb_fetch_queue;

    localparam int XLEN  = core_pkg::XLEN;
    localparam int FW    = core_pkg::FETCH_WIDTH;
    localparam int DEPTH = core_pkg::FQ_DEPTH;

    logic                      clk;
    logic                      reset;
    logic                      flush;
    logic [FW-1:0]             if_valid;
    logic [FW-1:0][XLEN-1:0]   if_pc;
    logic [FW-1:0][XLEN-1:0]   if_instr;
    logic                      stall;
    logic [FW-1:0]             id_valid;
    logic [FW-1:0][XLEN-1:0]   id_pc;
    logic [FW-1:0][XLEN-1:0]   id_instr;
    logic                      id_ready;
    logic [$clog2(DEPTH):0]    fq_count;

    int checks = 0;
    int errors = 0;

    logic [2*XLEN-1:0] model_q[$];

    fetch_queue #(.XLEN(XLEN), .FETCH_W(FW), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .reset    (reset),
        .flush    (flush),
        .if_valid (if_valid),
        .if_pc    (if_pc),
        .if_instr (if_instr),
        .stall    (stall),
        .id_valid (id_valid),
        .id_pc    (id_pc),
        .id_instr (id_instr),
        .id_ready (id_ready),
        .fq_count (fq_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [XLEN-1:0] instr_of(input logic [XLEN-1:0] pc);
        return pc ^ 32'hA5A5_0000;
    endfunction

    // Apply the queue rules to the model using the inputs present this cycle.
    task automatic model_apply();
        bit full;
        int n;
        full = (model_q.size() > DEPTH - FW);
        if (!reset || flush) begin
            model_q.delete();
        end else begin
            if (id_ready) begin
                n = (model_q.size() < FW) ? model_q.size() : FW;
                repeat (n) void'(model_q.pop_front());
            end
            if (!full) begin
                for (int s = 0; s < FW; s++)
                    if (if_valid[s]) model_q.push_back({if_pc[s], if_instr[s]});
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        model_apply();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pair(input logic [XLEN-1:0] pc);
        if_valid    = '1;
        if_pc[0]    = pc;
        if_pc[1]    = pc + 4;
        if_instr[0] = instr_of(pc);
        if_instr[1] = instr_of(pc + 4);
    endtask

    task automatic test_reset();
        reset = 1'b0; flush = 1'b0; id_ready = 1'b0;
        if_valid = '0; if_pc = '0; if_instr = '0;
        tick();
        tick();
        reset = 1'b1;
        #1;
        checks++;
        if (id_valid !== 2'b00) begin errors++; $display("FAIL reset_id_valid got %b want 00", id_valid); end
        checks++;
        if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b want 0", stall); end
        checks++;
        if (fq_count !== 0) begin errors++; $display("FAIL reset_count got %0d want 0", fq_count); end
        $display("test_reset done count=%0d", fq_count);
    endtask

    task automatic test_pass_through();
        id_ready = 1'b1;
        set_pair(32'h0);
        if_instr[0] = 32'h1111_1111;
        if_instr[1] = 32'h2222_2222;
        #1;
        checks++;
        if (id_valid !== 2'b00) begin errors++; $display("FAIL pt_empty got %b want 00", id_valid); end
        tick();
        if_valid = '0;
        #1;
        checks++;
        if (id_valid !== 2'b11 || id_pc[0] !== 32'h0 || id_instr[0] !== 32'h1111_1111
            || id_pc[1] !== 32'h4 || id_instr[1] !== 32'h2222_2222) begin
            errors++;
            $display("FAIL pass_through got v=%b %h:%h %h:%h want 11 00000000:11111111 00000004:22222222",
                     id_valid, id_pc[0], id_instr[0], id_pc[1], id_instr[1]);
        end
        tick();
        checks++;
        if (fq_count !== 0) begin errors++; $display("FAIL pt_drained got %0d want 0", fq_count); end
        $display("test_pass_through done");
    endtask

    task automatic test_fill();
        id_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            set_pair(32'(k * 8));
            #1;
            checks++;
            if (stall !== 1'b0) begin errors++; $display("FAIL fill_stall_low k=%0d got %b want 0", k, stall); end
            tick();
            checks++;
            if (fq_count !== 2 * (k + 1)) begin
                errors++; $display("FAIL fill_count k=%0d got %0d want %0d", k, fq_count, 2 * (k + 1));
            end
        end
        set_pair(32'h20);
        for (int k = 0; k < 2; k++) begin
            #1;
            checks++;
            if (stall !== 1'b1 || fq_count !== DEPTH) begin
                errors++; $display("FAIL fill_full got stall=%b count=%0d want 1 %0d", stall, fq_count, DEPTH);
            end
            tick();
        end
        checks++;
        if (id_pc[0] !== 32'h0 || id_pc[1] !== 32'h4) begin
            errors++; $display("FAIL fill_head got %h %h want 00000000 00000004", id_pc[0], id_pc[1]);
        end
        $display("test_fill done count=%0d", fq_count);
    endtask

    task automatic test_drain_wrap();
        logic [XLEN-1:0] next_in;
        logic [XLEN-1:0] exp_out;
        bit accepted;
        next_in  = 32'h20;
        exp_out  = 32'h0;
        id_ready = 1'b1;
        for (int cyc = 0; cyc < 20 && exp_out < 32'h30; cyc++) begin
            #1;
            checks++;
            if (stall !== (model_q.size() > DEPTH - FW)) begin
                errors++; $display("FAIL drain_stall cyc=%0d got %b size=%0d", cyc, stall, model_q.size());
            end
            for (int i = 0; i < FW; i++) begin
                if (id_valid[i]) begin
                    checks++;
                    if (id_pc[i] !== exp_out || id_instr[i] !== instr_of(exp_out)) begin
                        errors++; $display("FAIL drain_order cyc=%0d slot=%0d got %h want %h", cyc, i, id_pc[i], exp_out);
                    end
                    exp_out = exp_out + 4;
                end
            end
            accepted = (if_valid != '0) && !(model_q.size() > DEPTH - FW);
            tick();
            if (accepted) begin
                next_in = next_in + 8;
                if (next_in >= 32'h30) if_valid = '0;
                else set_pair(next_in);
            end
        end
        checks++;
        if (exp_out !== 32'h30 || fq_count !== 0) begin
            errors++; $display("FAIL drain_end got next=%h count=%0d want 00000030 0", exp_out, fq_count);
        end
        $display("test_drain_wrap done last_pc=%h", exp_out - 4);
    endtask

    task automatic test_partial();
        id_ready    = 1'b0;
        if_valid    = 2'b10;
        if_pc[0]    = 32'hDEAD_BEEF;
        if_instr[0] = 32'h0;
        if_pc[1]    = 32'h24;
        if_instr[1] = instr_of(32'h24);
        tick();
        if_valid = '0;
        #1;
        checks++;
        if (id_valid !== 2'b01 || id_pc[0] !== 32'h24 || id_instr[0] !== instr_of(32'h24)) begin
            errors++; $display("FAIL partial got v=%b pc=%h want 01 00000024", id_valid, id_pc[0]);
        end
        id_ready = 1'b1;
        tick();
        $display("test_partial done");
    endtask

    task automatic test_flush();
        id_ready = 1'b0;
        set_pair(32'h100); tick();
        set_pair(32'h108); tick();
        if_valid = 2'b01; if_pc[0] = 32'h110; if_instr[0] = instr_of(32'h110); tick();
        checks++;
        if (fq_count !== 5) begin errors++; $display("FAIL flush_pre got %0d want 5", fq_count); end
        flush = 1'b1;
        set_pair(32'h08);
        #1;
        checks++;
        if (id_valid !== 2'b00) begin errors++; $display("FAIL flush_valid got %b want 00", id_valid); end
        tick();
        flush = 1'b0;
        if_valid = 2'b01; if_pc[0] = 32'h08; if_instr[0] = instr_of(32'h08);
        #1;
        checks++;
        if (fq_count !== 0 || stall !== 1'b0 || id_valid !== 2'b00) begin
            errors++; $display("FAIL flush_empty got count=%0d stall=%b v=%b want 0 0 00", fq_count, stall, id_valid);
        end
        tick();
        if_valid = '0;
        #1;
        checks++;
        if (id_valid !== 2'b01 || id_pc[0] !== 32'h08) begin
            errors++; $display("FAIL flush_refill got v=%b pc=%h want 01 00000008", id_valid, id_pc[0]);
        end
        id_ready = 1'b1;
        tick();
        $display("test_flush done");
    endtask

    task automatic test_random();
        logic [FW-1:0] exp_v;
        for (int cyc = 0; cyc < 600; cyc++) begin
            reset    = ($urandom_range(59) != 0);
            flush    = ($urandom_range(19) == 0);
            id_ready = ($urandom_range(2) != 0);
            if_valid = FW'($urandom);
            for (int s = 0; s < FW; s++) begin
                if_pc[s]    = $urandom;
                if_instr[s] = $urandom;
            end
            #1;
            for (int i = 0; i < FW; i++) exp_v[i] = (model_q.size() > i) && !flush;
            checks++;
            if (id_valid !== exp_v || stall !== (model_q.size() > DEPTH - FW) || fq_count !== model_q.size()) begin
                errors++;
                $display("FAIL rand_ctrl cyc=%0d got v=%b stall=%b count=%0d want v=%b count=%0d",
                         cyc, id_valid, stall, fq_count, exp_v, model_q.size());
            end
            for (int i = 0; i < FW; i++) begin
                if (exp_v[i]) begin
                    checks++;
                    if ({id_pc[i], id_instr[i]} !== model_q[i]) begin
                        errors++;
                        $display("FAIL rand_data cyc=%0d slot=%0d got %h:%h want %h", cyc, i, id_pc[i], id_instr[i], model_q[i]);
                    end
                end
            end
            tick();
        end
        reset = 1'b1; flush = 1'b0; if_valid = '0;
        $display("test_random done final_count=%0d", fq_count);
    endtask

    initial begin
        test_reset();
        test_pass_through();
        test_fill();
        test_drain_wrap();
        test_partial();
        test_flush();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Decoupling instruction queue between `fetch` and decode. It accepts up to `FETCH_WIDTH` instructions per cycle from fetch (`if_valid/if_pc/if_instr`) and presents up to `FETCH_WIDTH` in-order instructions to decode. It back-pressures fetch through the `stall` output and discards all contents on a redirect flush. Storage is a circular buffer of PC/instruction pairs.

## Interface
- `XLEN`, default `core_pkg::XLEN`: PC and instruction width.
- `FETCH_W`, default `core_pkg::FETCH_WIDTH` (2): enqueue and dequeue width.
- `DEPTH`, default `core_pkg::FQ_DEPTH` (8): entries; must be a power of 2 and at least `2*FETCH_W`.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-low. `reset==0` at a rising edge resets the queue.
- `flush` in 1: redirect or mispredict. Empties the queue.
- `if_valid` in `FETCH_W`: per-slot valid from fetch.
- `if_pc` in `FETCH_W` x `XLEN`: slot PCs.
- `if_instr` in `FETCH_W` x `XLEN`: slot instructions.
- `stall` out 1: to fetch. Fetch holds its outputs while this is high.
- `id_valid` out `FETCH_W`: per-slot valid to decode. Bit 0 is the oldest entry.
- `id_pc` out `FETCH_W` x `XLEN`: PCs of the head entries.
- `id_instr` out `FETCH_W` x `XLEN`: instructions of the head entries.
- `id_ready` in 1: decode consumes every asserted `id_valid` slot this cycle.
- `fq_count` out `$clog2(DEPTH)+1`: occupancy, for debug and perf counters.

## Operation
- **State:** `head` and `tail` pointers (`$clog2(DEPTH)` bits, natural wrap), `count` register, `entry[DEPTH]` of `fq_entry_t`.
- **Enqueue:**
  - Enqueue only happens when `stall==0` and `flush==0`.
  - Valid slots are compacted in slot order. `if_valid=2'b10` writes `if_*[1]` at `tail`; `2'b11` writes slot 0 at `tail` and slot 1 at `tail+1`.
  - `enq_n = popcount(if_valid)`.
  - When `stall==1`, inputs are ignored; fetch re-presents them.
- **Dequeue:**
  - `id_valid[i] = (count > i) && !flush`.
  - `id_pc[i]` and `id_instr[i]` come from `entry[head+i]` (wrapped).
  - When `id_ready==1`, `deq_n = popcount(id_valid)`.
  - Outputs are driven only from registers, with no combinational path from the `if_*` inputs.
  - Invalid slots still show the stale `entry` contents; consumers must ignore them.
- **Stall:** `stall = (count > DEPTH - FETCH_W)`, computed from the registered `count` only. The same-cycle dequeue is ignored, which is conservative, so overflow is impossible.
- **Update:**
  - `count <= count + enq_n - deq_n`.
  - `tail += enq_n`, `head += deq_n`, modulo `DEPTH`.
  - Simultaneous enqueue and dequeue are legal in the same cycle.
- **Flush:** `head`, `tail` and `count` go to 0 at the edge. Same-cycle enqueue and dequeue are dropped. Entry contents are not cleared.
- **Priority:** `reset` > `flush` > enqueue/dequeue.
- **Assertions:** `count <= DEPTH`; no underflow (`deq_n <= count`).

## Timing
- **Reset values:** `stall=0`, `id_valid=0`, `fq_count=0`. Pointers are 0. `id_pc`/`id_instr` are don't-care (entry array is not reset).
- **Latency:** an instruction enqueued at edge N is visible on `id_*` after edge N, i.e. in the cycle following acceptance. There is no bypass; minimum fetch-to-decode delay is 1 cycle.
- **Full boundary:** with `DEPTH=8`, `stall` is high when `count` is 7 or 8. It falls the cycle after `count` drops to 6 or below.
- **Empty boundary:** `count=0` gives `id_valid=0`. `id_ready` is a don't-care.
- **Wrap-around:** a two-entry enqueue or dequeue may straddle index `DEPTH-1` → 0.
- **Flush with reset deasserted mid-stream:** the queue is empty the next cycle, and `stall` is low the next cycle.
- **Reset mid-operation:** same effect as flush, plus `stall=0` next cycle.

## Structure
- Add to `core_pkg`:
  - `localparam int FQ_DEPTH = 8;`
  - `typedef struct packed { logic [XLEN-1:0] pc; logic [XLEN-1:0] instr; } fq_entry_t;`
- The block is a single module, `fetch_queue`. No sub-module is warranted; popcount is an inline function.

## Test plan
- **Reset:** hold `reset=0` for 2 cycles → `id_valid=00`, `stall=0`, `fq_count=0`.
- **Pass-through:** enqueue `{0x04:0x22222222, 0x00:0x11111111}` with `id_ready=1` → next cycle `id_valid=11` with slot0 PC=0x00/0x11111111 and slot1 PC=0x04/0x22222222. `count` returns to 0 after the dequeue.
- **Fill:** `id_ready=0`, enqueue pairs from PC 0x00 → `fq_count` goes 2, 4, 6, 8. `stall=1` once `count=8`. Inputs held during stall are not duplicated; the queue holds PCs 0x00–0x1C.
- **Drain with wrap:** from full, `id_ready=1` while enqueuing pairs from 0x20 → output PCs strictly ascend 0x00, 0x04, …, 0x2C across the index 7→0 wrap, with no gaps or repeats.
- **Partial and compaction:** `if_valid=10` with slot1 PC=0x24 into an empty queue → next cycle `id_valid=01`, `id_pc[0]=0x24`.
- **Flush:** queue holding 5 entries; `flush=1` together with an enqueue of 0x08/0x0C → `id_valid=00` in the flush cycle and `count=0` next cycle. The following enqueue of 0x08 appears at `id_pc[0]`.
